// File: rtl/serial_chunk_adder_pkg.sv
// Shared types and parameter derivations for the chunk-serial adder.
// Subtraction support is enabled by defining SERIAL_CHUNK_ADDER_SUB_EN.
package serial_chunk_adder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  // Guard against CHUNK=0 so an illegal configuration still elaborates far
  // enough to report the parameter error.
  function automatic int calc_nchunk(input int width, input int chunk);
    return (chunk < 1) ? 1 : width / chunk;
  endfunction

  function automatic int calc_cnt_w(input int nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

  function automatic bit params_ok(input int width, input int chunk);
    return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/serial_chunk_adder_chunk_adder.sv
// CHUNK-bit ripple chain of full-adder cells; also reports the carry into
// its MSB so the parent can form signed overflow.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             c_i,
  output logic [CHUNK-1:0] s_o,
  output logic             c_o,
  output logic             c_msb_o
);

  always_comb begin
    logic carry;
    carry   = c_i;
    s_o     = '0;
    c_msb_o = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      if (i == CHUNK - 1) c_msb_o = carry;
      s_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry  = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    c_o = carry;
  end

endmodule

// File: rtl/serial_chunk_adder.sv
// Multi-cycle adder: WIDTH-bit operands summed CHUNK bits per clock, LSB first.
// Define SERIAL_CHUNK_ADDER_SUB_EN to add the sub port (a - b).
module serial_chunk_adder
  import serial_chunk_adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carryin,
`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carryout,
  output logic             overflow,
  output state_t           state_dbg
);

  localparam int NCHUNK = calc_nchunk(WIDTH, CHUNK);
  localparam int CNT_W  = calc_cnt_w(NCHUNK);

  if (!params_ok(WIDTH, CHUNK)) begin : g_bad_params
    $error("serial_chunk_adder: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high. in_ready/out_valid decode registered state only.
  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d, sum_q, sum_d;
  logic               c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [WIDTH-1:0]   b_eff;
  logic               c_eff;
  logic [CHUNK-1:0]   ch_s;
  logic               ch_co, ch_cmsb;
  logic [WIDTH-1:0]   acc_shift;

`ifdef SERIAL_CHUNK_ADDER_SUB_EN
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? 1'b1 : carryin;
`else
  assign b_eff = b;
  assign c_eff = carryin;
`endif

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i     (a_q[CHUNK-1:0]),
    .b_i     (b_q[CHUNK-1:0]),
    .c_i     (c_q),
    .s_o     (ch_s),
    .c_o     (ch_co),
    .c_msb_o (ch_cmsb)
  );

  // Working sum shifts in from the top; the visible sum only changes at the
  // final chunk so it holds the previous result during RUN.
  assign acc_shift = (acc_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b_eff;
          c_d     = c_eff;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = ch_co;
        acc_d = acc_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          sum_d   = acc_shift;
          cout_d  = ch_co;
          ovf_d   = ch_co ^ ch_cmsb;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign sum       = sum_q;
  assign carryout  = cout_q;
  assign overflow  = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: doc/serial_chunk_adder.md
# serial_chunk_adder

Multi-cycle, parametrised N-bit adder.
- Processes `WIDTH`-bit operands `CHUNK` bits per clock, least-significant chunk first, with a registered ripple carry between chunks.
- Accepts one operation via a valid/ready input handshake and returns `sum`, `carryout` and signed `overflow` via a valid/ready output handshake.
- Sits in the datapath where area matters more than latency. Built from the team's full-adder cells.

## Interface
Parameters:
- `WIDTH`, default 32: operand and sum width. `WIDTH % CHUNK == 0` is required.
- `CHUNK`, default 4: bits added per cycle, 1 ≤ `CHUNK` ≤ `WIDTH`. `NCHUNK = WIDTH/CHUNK`.

Ports:
- `clk` input, 1: single clock. All state updates on the rising edge.
- `reset` input, 1: synchronous, active-high.
- `in_valid` input, 1: operands present.
- `in_ready` output, 1: block can accept. High only in IDLE.
- `a` input, `WIDTH`: operand A.
- `b` input, `WIDTH`: operand B.
- `carryin` input, 1: carry into bit 0.
- `sub` input, 1: subtract select. Present only with `SERIAL_CHUNK_ADDER_SUB_EN`.
- `out_valid` output, 1: result valid.
- `out_ready` input, 1: consumer takes result.
- `sum` output, `WIDTH`: result.
- `carryout` output, 1: carry out of bit `WIDTH-1`.
- `overflow` output, 1: signed overflow, i.e. carry into MSB XOR carry out of MSB.

## Operation
State machine:
- **IDLE:** `in_ready`=1. On `in_valid`&&`in_ready`, capture `a`, `b` and `carryin` into shift/carry registers, clear the chunk counter, go to RUN.
- **RUN:** each cycle:
  - Add the low `CHUNK` bits of the A/B shift registers plus the carry register.
  - Store the chunk carry-out.
  - Shift the chunk sum into the top of the sum register (right shift by `CHUNK`); shift A/B right by `CHUNK`.
  - Increment the counter.
  - On the cycle where counter == `NCHUNK-1`: also latch `carryout` and `overflow` from the top chunk, then go to DONE.
- **DONE:** `out_valid`=1. `sum`, `carryout` and `overflow` are stable. On `out_ready`, go to IDLE.

Arithmetic and width rules:
- Result equals `{carryout,sum} = a + b + carryin`, modulo 2^(`WIDTH`+1).
- Counter width is max(1, clog2(`NCHUNK`)).
- `NCHUNK`=1 is legal: RUN lasts one cycle.

Output and handshake rules:
- `sum`, `carryout` and `overflow` hold their last result outside DONE. They are meaningful only while `out_valid`=1.
- Operand changes on `a`/`b` after acceptance have no effect.
- `in_valid` outside IDLE is ignored; no queuing.

Reset:
- Reset wins over every other event in the same cycle.
- After reset: state=IDLE, `in_ready`=1, `out_valid`=0, `sum`=0, `carryout`=0, `overflow`=0, counter=0, internal carry=0.
- Reset mid-RUN or in DONE abandons the operation. No `out_valid` pulse is produced for it.

## Timing
- Accepting edge T moves the block to RUN.
- Chunks are added on edges T+1 … T+`NCHUNK`.
- `out_valid` is high in the cycle after edge T+`NCHUNK`, i.e. `NCHUNK` cycles after acceptance.
- With `out_ready` held high: DONE lasts one cycle and `in_ready` is high on the next cycle. Peak throughput is one operation per `NCHUNK`+2 cycles.
- `in_ready` and `out_valid` are decoded from registered state only; no combinational path from `out_ready` or `in_valid`.
- Critical path is one `CHUNK`-bit ripple plus register.

## Configuration
`SERIAL_CHUNK_ADDER_SUB_EN`:
- **Defined:** `sub` port exists. When `sub`=1 at acceptance:
  - Capture ~`b` and force carry-in to 1; `carryin` is ignored. Result is `a - b`.
  - `carryout`=1 means no borrow.
  - `overflow` uses the same MSB carry rule.
  - `sub`=0 behaves exactly as the add-only build.
- **Undefined:** no `sub` port. Addition only.

## Structure
- Shared package `serial_chunk_adder_pkg` holds:
  - state typedef: IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the `NCHUNK` and counter-width derivations;
  - the legality checks on `WIDTH`/`CHUNK`.
- One sub-module, `chunk_adder`: `CHUNK`-bit ripple chain of structural full adders. Outputs are chunk sum, carry-out and carry into its MSB (for overflow).

## Test plan
All scenarios use `WIDTH`=32, `CHUNK`=4 (`NCHUNK`=8) unless noted.
- Reset, then `a`=0x00000005, `b`=0x00000003, `carryin`=0 → `out_valid` exactly 8 cycles after accept; `sum`=0x00000008, `carryout`=0, `overflow`=0. `in_ready`=0 throughout RUN/DONE.
- `a`=0xFFFFFFFF, `b`=0x00000001 → `sum`=0, `carryout`=1, `overflow`=0. Then `a`=0x7FFFFFFF, `b`=1 → `sum`=0x80000000, `carryout`=0, `overflow`=1. Then `a`=`b`=0, `carryin`=1 → `sum`=1.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE and drive `in_valid` with new operands → `out_valid` and `sum` held, new operands not accepted. Release `out_ready` → IDLE next cycle, next accept succeeds.
- Assert `reset` on the 3rd RUN cycle → next cycle `in_ready`=1, `out_valid`=0, `sum`=0. A following operation 0x12345678+0x11111111 gives 0x23456789.
- Parameter corners: `CHUNK`=1 (32-cycle latency) and `CHUNK`=32 (1-cycle RUN), each run on 1000 random operands → match `a+b+carryin` and `overflow` from a reference model.
- With `SERIAL_CHUNK_ADDER_SUB_EN`: `sub`=1, `a`=5, `b`=7 → `sum`=0xFFFFFFFE, `carryout`=0. `a`=7, `b`=5 → `sum`=2, `carryout`=1. `a`=0x80000000, `b`=1 → `overflow`=1.
